shift_reg_sequencer: RTL

SHIFT_REG_SEQUENCER -- requirements
Module: shift_reg_sequencer

---
 rtl/shift_reg_sequencer.sv | 191 +++++++++++++++++++
 1 files changed

// File: rtl/shift_reg_sequencer.sv
// ---------------------------------------------------------------------------
// shift_reg_sequencer
//
// Sequences commands onto an external 4-bit shift register. Commands enter a
// small FIFO. They are then executed in order by a four-state FSM:
//   IDLE  -> LOAD  -> SHIFT -> DONE -> IDLE
// The FSM skips LOAD for pure shift ops and skips SHIFT when the count is 0.
// The result is always read back from the external shifter (sr_q); this
// block never models the shift itself.
//
// Ports
//   clk        : single clock, rising edge
//   rst_n      : asynchronous active-low reset
//   cmd_valid  : command fields are valid
//   cmd_ready  : FIFO has room; low only when the FIFO is full
//   cmd_op     : 00 shr, 01 shl, 10 load+shr, 11 load+shl
//   cmd_cnt    : number of shift cycles, 0-15
//   cmd_data   : load value; used by ops 10/11 only
//   sr_en      : shifter enable (registered)
//   sr_sel     : shifter select 00 right, 01 left, 10 hold, 11 load (registered)
//   sr_in      : shifter parallel-load data (registered)
//   sr_q       : shifter registered output
//   rsp_valid  : one-cycle completion pulse (DONE state)
//   rsp_data   : sr_q while rsp_valid, else 0
//   busy       : FSM not idle or FIFO not empty
// ---------------------------------------------------------------------------
module shift_reg_sequencer #(
    parameter int FIFO_DEPTH = 2
) (
    input  logic       clk,
    input  logic       rst_n,
    input  logic       cmd_valid,
    output logic       cmd_ready,
    input  logic [1:0] cmd_op,
    input  logic [3:0] cmd_cnt,
    input  logic [3:0] cmd_data,
    output logic       sr_en,
    output logic [1:0] sr_sel,
    output logic [3:0] sr_in,
    input  logic [3:0] sr_q,
    output logic       rsp_valid,
    output logic [3:0] rsp_data,
    output logic       busy
);

    localparam int PTR_W = (FIFO_DEPTH > 1) ? $clog2(FIFO_DEPTH) : 1;
    localparam int CNT_W = $clog2(FIFO_DEPTH + 1);

    localparam logic [1:0] SEL_RIGHT = 2'b00;
    localparam logic [1:0] SEL_LEFT  = 2'b01;
    localparam logic [1:0] SEL_HOLD  = 2'b10;
    localparam logic [1:0] SEL_LOAD  = 2'b11;

    typedef enum logic [1:0] {
        IDLE,
        LOAD,
        SHIFT,
        DONE
    } state_t;

    typedef struct packed {
        logic [1:0] op;
        logic [3:0] cnt;
        logic [3:0] data;
    } cmd_t;

    cmd_t             fifo_mem [FIFO_DEPTH];
    logic [PTR_W-1:0] wr_ptr;
    logic [PTR_W-1:0] rd_ptr;
    logic [CNT_W-1:0] count;
    cmd_t             head;
    logic             push;
    logic             pop;

    state_t           state;
    logic [3:0]       shift_cnt;
    logic             shift_left;

    function automatic logic [PTR_W-1:0] ptr_next(input logic [PTR_W-1:0] p);
        return (p == PTR_W'(FIFO_DEPTH - 1)) ? '0 : p + PTR_W'(1);
    endfunction

    function automatic logic [1:0] shift_sel(input logic left);
        return left ? SEL_LEFT : SEL_RIGHT;
    endfunction

    // Ready depends only on registered occupancy, never on cmd_valid.
    assign cmd_ready = (count != CNT_W'(FIFO_DEPTH));
    assign push      = cmd_valid && cmd_ready;
    // The FSM pops the head only from IDLE; a push on the same edge still lands.
    assign pop       = (state == IDLE) && (count != '0);
    assign head      = fifo_mem[rd_ptr];

    assign busy      = (state != IDLE) || (count != '0);
    // DONE is entered on the edge of the final shift, so the result must be
    // read live from sr_q during DONE rather than captured on that edge.
    assign rsp_valid = (state == DONE);
    assign rsp_data  = (state == DONE) ? sr_q : 4'h0;

    // NOTE: FIFO storage has no reset; only the pointers and occupancy need
    // one, since an entry is never read before it has been written.
    always_ff @(posedge clk) begin
        if (push) begin
            fifo_mem[wr_ptr] <= '{op: cmd_op, cnt: cmd_cnt, data: cmd_data};
        end
    end

    // NOTE: sequential state uses non-blocking assignments so every flop
    // samples pre-edge values regardless of statement order.
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            wr_ptr <= '0;
            rd_ptr <= '0;
            count  <= '0;
        end else begin
            if (push) wr_ptr <= ptr_next(wr_ptr);
            if (pop)  rd_ptr <= ptr_next(rd_ptr);
            count <= count + CNT_W'(push) - CNT_W'(pop);
        end
    end

    // FSM with registered shifter controls. The outputs are assigned for the
    // state being entered, so they line up with that state's cycle.
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            state      <= IDLE;
            shift_cnt  <= 4'd0;
            shift_left <= 1'b0;
            sr_en      <= 1'b0;
            sr_sel     <= SEL_HOLD;
            sr_in      <= 4'h0;
        end else begin
            // Idle controls unless the next state is LOAD or SHIFT.
            sr_en  <= 1'b0;
            sr_sel <= SEL_HOLD;
            sr_in  <= 4'h0;

            case (state)
                IDLE: begin
                    if (pop) begin
                        shift_left <= head.op[0];
                        shift_cnt  <= head.cnt;
                        if (head.op[1]) begin
                            state  <= LOAD;
                            sr_en  <= 1'b1;
                            sr_sel <= SEL_LOAD;
                            sr_in  <= head.data;
                        end else if (head.cnt != 4'd0) begin
                            state  <= SHIFT;
                            sr_en  <= 1'b1;
                            sr_sel <= shift_sel(head.op[0]);
                        end else begin
                            state <= DONE;
                        end
                    end
                end

                LOAD: begin
                    if (shift_cnt != 4'd0) begin
                        state  <= SHIFT;
                        sr_en  <= 1'b1;
                        sr_sel <= shift_sel(shift_left);
                    end else begin
                        state <= DONE;
                    end
                end

                SHIFT: begin
                    // shift_cnt counts the SHIFT cycles still to run,
                    // including the current one.
                    shift_cnt <= shift_cnt - 4'd1;
                    if (shift_cnt == 4'd1) begin
                        state <= DONE;
                    end else begin
                        sr_en  <= 1'b1;
                        sr_sel <= shift_sel(shift_left);
                    end
                end

                DONE: begin
                    state <= IDLE;
                end

                default: begin
                    state <= IDLE;
                end
            endcase
        end
    end

endmodule
